// File: rtl/i2c_master_arbiter.sv
// Round-robin, two-requester transaction controller in front of the basic I2C master.
// Optional watchdog abort is compiled in when I2C_ARB_TIMEOUT_EN is defined.
module i2c_master_arbiter #(
  parameter int ADDR_BIT       = 7,
  parameter int LEN_BIT        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [1:0]                        req,
  input  logic [2*ADDR_BIT-1:0]             req_addr,
  input  logic [1:0]                        req_rw,
  input  logic [2*LEN_BIT-1:0]              req_len,
  output logic [1:0]                        gnt,
  output logic [1:0]                        done,
  output logic [1:0]                        err,
  output logic                              m_start,
  output logic                              m_stop,
  output logic [ADDR_BIT-1:0]               m_addr,
  output logic                              m_rw,
  input  logic [2:0]                        m_state,
  input  logic                              m_sda,
  output logic [1:0]                        dbg_state,
  output logic [LEN_BIT-1:0]                dbg_bytes,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0] dbg_wd,
  output logic                              dbg_ack_sda
);
  // Handshake: req[i] is a level held until done[i]; gnt[i] is high from the grant
  // cycle until the done cycle, and done/err pulse for exactly one cycle.
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_XFER, S_FINISH} state_e;
  localparam logic [2:0] M_IDLE = 3'd0, M_ACK_ADDR = 3'd3, M_ACK_WR_RD = 3'd5, M_STOP = 3'd6;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic                ptr_q, ptr_d;
  logic [ADDR_BIT-1:0] addr_q, addr_d;
  logic                rw_q, rw_d, start_q, start_d, err_flag_q, err_flag_d, sda_q;
  logic [LEN_BIT-1:0]  len_q, len_d, bytes_q, bytes_d;
  logic [2:0]          prev_q;
  logic                win, stop_c, abort;

  assign win    = (req == 2'b11) ? ~ptr_q : req[1];
  assign stop_c = ((state_q == S_XFER) || (state_q == S_FINISH)) && (bytes_q == len_q);

`ifdef I2C_ARB_TIMEOUT_EN
  // Counts cycles since the last master state change, the changing cycle included.
  logic [WD_W-1:0] wd_q, wd_d;
  always_comb begin
    wd_d = wd_q;
    if (state_q == S_IDLE)    wd_d = '0;
    else if (m_state != prev_q) wd_d = WD_W'(1);
    else if (wd_q != '1)      wd_d = wd_q + 1'b1;
  end
  assign abort = (state_q != S_IDLE) && (m_state == prev_q) &&
                 (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wd_q <= '0;
    else          wd_q <= wd_d;
  end
  assign dbg_wd = wd_q;
`else
  assign abort  = 1'b0;
  assign dbg_wd = '0;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    len_d      = len_q;
    bytes_d    = bytes_q;
    start_d    = start_q;
    err_flag_d = err_flag_q;
    done_d     = 2'b00;
    err_d      = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = win ? 2'b10 : 2'b01;
          addr_d  = win ? req_addr[2*ADDR_BIT-1:ADDR_BIT] : req_addr[ADDR_BIT-1:0];
          rw_d    = req_rw[win];
          len_d   = win ? req_len[2*LEN_BIT-1:LEN_BIT] : req_len[LEN_BIT-1:0];
          bytes_d = '0;
          err_flag_d = 1'b0;
          start_d = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (m_state != M_IDLE) begin
          start_d = 1'b0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        // A byte ends when the master leaves ACK_WR_RD; the count saturates.
        if ((prev_q == M_ACK_WR_RD) && (m_state != M_ACK_WR_RD) && (bytes_q != '1))
          bytes_d = bytes_q + 1'b1;
        if ((prev_q == M_ACK_ADDR) && (m_state == M_STOP)) err_flag_d = 1'b1;
        if ((prev_q == M_ACK_WR_RD) && (m_state == M_STOP) && !stop_c) err_flag_d = 1'b1;
        if (m_state == M_STOP) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (m_state == M_IDLE) begin
          done_d     = gnt_q;
          err_d      = err_flag_q ? gnt_q : 2'b00;
          gnt_d      = 2'b00;
          err_flag_d = 1'b0;
          ptr_d      = gnt_q[1];
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      done_d     = gnt_q;
      err_d      = gnt_q;
      gnt_d      = 2'b00;
      start_d    = 1'b0;
      err_flag_d = 1'b0;
      ptr_d      = gnt_q[1];
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      ptr_q      <= 1'b1;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      len_q      <= '0;
      bytes_q    <= '0;
      start_q    <= 1'b0;
      err_flag_q <= 1'b0;
      prev_q     <= M_IDLE;
      sda_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      len_q      <= len_d;
      bytes_q    <= bytes_d;
      start_q    <= start_d;
      err_flag_q <= err_flag_d;
      prev_q     <= m_state;
      if ((m_state == M_ACK_ADDR) || (m_state == M_ACK_WR_RD)) sda_q <= m_sda;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign err         = err_q;
  assign m_start     = start_q;
  assign m_stop      = stop_c;
  assign m_addr      = addr_q;
  assign m_rw        = rw_q;
  assign dbg_state   = state_q;
  assign dbg_bytes   = bytes_q;
  assign dbg_ack_sda = sda_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: a scripted I2C master model plus a round-robin / byte-count
// reference model. Define I2C_ARB_TIMEOUT_EN to include the watchdog scenario.
module tb_i2c_master_arbiter;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_START = 3'd1, ST_ADDR = 3'd2, ST_ACK_ADDR = 3'd3,
                         ST_WR_RD = 3'd4, ST_ACK_WR_RD = 3'd5, ST_STOP = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req, req_rw;
  logic [13:0] req_addr;
  logic [7:0]  req_len;
  logic [1:0]  gnt, done, err;
  logic        m_start, m_stop, m_rw, m_sda, dbg_ack_sda;
  logic [6:0]  m_addr;
  logic [2:0]  m_state;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_bytes;
  logic [4:0]  dbg_wd;

  int total = 0;
  int bad   = 0;
  int exp_last = 1;
  logic [6:0] a_addr [2];
  logic       a_rw   [2];
  int         a_len  [2];

  typedef struct {
    logic [1:0]  gnt, done, err, post_gnt, start;
    logic [6:0]  addr;
    logic        rw, gnt_at_done, done_after;
    logic [31:0] stop;
    logic [3:0]  dbytes;
    int          bytes, glat, dlat;
  } obs_t;

  i2c_master_arbiter #(.ADDR_BIT(7), .LEN_BIT(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_len(req_len), .gnt(gnt), .done(done), .err(err), .m_start(m_start), .m_stop(m_stop),
    .m_addr(m_addr), .m_rw(m_rw), .m_state(m_state), .m_sda(m_sda), .dbg_state(dbg_state),
    .dbg_bytes(dbg_bytes), .dbg_wd(dbg_wd), .dbg_ack_sda(dbg_ack_sda)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog sim_time_exceeded got=running exp=finished");
    $fatal(1);
  end

  function automatic logic [1:0] rr_pick(input logic [1:0] r);
    if (r == 2'b11) return (exp_last == 0) ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic drive_state(input logic [2:0] st);
    m_state = st;
    repeat ($urandom_range(2, 1)) @(negedge clk);
  endtask

  task automatic load_bus();
    req_addr = {a_addr[1], a_addr[0]};
    req_rw   = {a_rw[1], a_rw[0]};
    req_len  = {4'(a_len[1]), 4'(a_len[0])};
  endtask

  // mode 0: all ACK, 1: address NACK, 2: data NACK at byte nb (1-based)
  task automatic run_txn(input logic [1:0] req_v, input int mode, input int nb, output obs_t o);
    int g;
    bit fin;
    o = '{default: 0};
    load_bus();
    req = req_v;
    m_state = ST_IDLE;
    while (gnt === 2'b00 && o.glat < 20) begin @(negedge clk); o.glat++; end
    o.gnt = gnt; o.addr = m_addr; o.rw = m_rw; o.start[1] = m_start;
    if (gnt === 2'b00) return;
    g = (gnt === 2'b10) ? 1 : 0;
    if (g == 1) begin
      req_addr[13:7] = 7'($urandom); req_rw[1] = 1'($urandom); req_len[7:4] = 4'($urandom);
    end else begin
      req_addr[6:0] = 7'($urandom); req_rw[0] = 1'($urandom); req_len[3:0] = 4'($urandom);
    end
    @(negedge clk);
    drive_state(ST_START);
    drive_state(ST_ADDR);
    o.start[0] = m_start;
    drive_state(ST_ACK_ADDR);
    if (mode != 1) begin
      fin = 0;
      while (!fin && o.bytes < 20) begin
        drive_state(ST_WR_RD);
        drive_state(ST_ACK_WR_RD);
        o.stop[o.bytes] = m_stop;
        o.bytes++;
        if (m_stop === 1'b1 || (mode == 2 && o.bytes == nb)) fin = 1;
      end
    end
    drive_state(ST_STOP);
    m_state = ST_IDLE;
    while (done === 2'b00 && o.dlat < 10) begin @(negedge clk); o.dlat++; end
    o.done = done; o.err = err; o.dbytes = dbg_bytes; o.gnt_at_done = |gnt;
    req[g] = 1'b0;
    @(negedge clk);
    o.post_gnt = gnt; o.done_after = |done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 2'b00; req_addr = '0; req_rw = '0; req_len = '0;
    m_state = ST_IDLE; m_sda = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({gnt, done, err, m_start, m_stop} !== 7'b0) begin bad++;
      $display("FAIL reset_outs got=%b exp=0", {gnt, done, err, m_start, m_stop}); end
    reset_n = 1'b1;
    @(negedge clk);
    total++; if ({m_addr, m_rw} !== 8'b0) begin bad++;
      $display("FAIL reset_latch got=%h exp=0", {m_addr, m_rw}); end
    total++; if (dbg_state !== 2'b00 || dbg_bytes !== 4'd0) begin bad++;
      $display("FAIL reset_state got=%0d/%0d exp=0/0", dbg_state, dbg_bytes); end
    exp_last = 1;
  endtask

  task automatic test_write_1byte();
    obs_t o;
    a_addr[0] = 7'h50; a_rw[0] = 1'b0; a_len[0] = 0;
    run_txn(2'b01, 0, 0, o);
    total++; if (o.gnt !== 2'b01) begin bad++; $display("FAIL w1_gnt got=%b exp=01", o.gnt); end
    total++; if (o.glat != 1) begin bad++; $display("FAIL w1_grant_latency got=%0d exp=1", o.glat); end
    total++; if (o.addr !== 7'h50 || o.rw !== 1'b0) begin bad++;
      $display("FAIL w1_addr got=%h/%b exp=50/0", o.addr, o.rw); end
    total++; if (o.start !== 2'b10) begin bad++; $display("FAIL w1_start got=%b exp=10", o.start); end
    total++; if (o.bytes != 1 || o.stop !== 32'h1) begin bad++;
      $display("FAIL w1_stop got=%0d/%h exp=1/1", o.bytes, o.stop); end
    total++; if (o.done !== 2'b01 || o.err !== 2'b00) begin bad++;
      $display("FAIL w1_done got=%b/%b exp=01/00", o.done, o.err); end
    total++; if (o.dlat != 1 || o.gnt_at_done || o.done_after) begin bad++;
      $display("FAIL w1_done_timing got=%0d/%b/%b exp=1/0/0", o.dlat, o.gnt_at_done, o.done_after); end
    exp_last = 0;
  endtask

  task automatic test_read_3byte();
    obs_t o;
    a_addr[1] = 7'h2A; a_rw[1] = 1'b1; a_len[1] = 2;
    run_txn(2'b10, 0, 0, o);
    total++; if (o.gnt !== 2'b10 || o.rw !== 1'b1) begin bad++;
      $display("FAIL r3_gnt got=%b/%b exp=10/1", o.gnt, o.rw); end
    total++; if (o.bytes != 3 || o.stop !== 32'h4) begin bad++;
      $display("FAIL r3_stop got=%0d/%h exp=3/4", o.bytes, o.stop); end
    total++; if (o.done !== 2'b10 || o.err !== 2'b00) begin bad++;
      $display("FAIL r3_done got=%b/%b exp=10/00", o.done, o.err); end
    exp_last = 1;
  endtask

  task automatic test_contention();
    obs_t o;
    a_addr[0] = 7'h11; a_addr[1] = 7'h22; a_rw[0] = 1'b0; a_rw[1] = 1'b1;
    a_len[0] = 1; a_len[1] = 1;
    run_txn(2'b11, 0, 0, o);
    total++; if (o.gnt !== 2'b01 || o.post_gnt !== 2'b10) begin bad++;
      $display("FAIL cont1_gnt got=%b/%b exp=01/10", o.gnt, o.post_gnt); end
    run_txn(2'b10, 0, 0, o);
    total++; if (o.gnt !== 2'b10 || o.glat != 0 || o.addr !== 7'h22) begin bad++;
      $display("FAIL cont2_gnt got=%b/%0d/%h exp=10/0/22", o.gnt, o.glat, o.addr); end
    run_txn(2'b01, 0, 0, o);
    exp_last = 0;
    run_txn(2'b11, 0, 0, o);
    total++; if (o.gnt !== 2'b10 || o.post_gnt !== 2'b01) begin bad++;
      $display("FAIL cont3_gnt got=%b/%b exp=10/01", o.gnt, o.post_gnt); end
    run_txn(2'b01, 0, 0, o);
    total++; if (o.gnt !== 2'b01 || o.done !== 2'b01) begin bad++;
      $display("FAIL cont4_gnt got=%b/%b exp=01/01", o.gnt, o.done); end
    exp_last = 0;
  endtask

  task automatic test_addr_nack();
    obs_t o;
    a_len[0] = 3;
    run_txn(2'b01, 1, 0, o);
    total++; if (o.done !== 2'b01 || o.err !== 2'b01) begin bad++;
      $display("FAIL anack_done got=%b/%b exp=01/01", o.done, o.err); end
    total++; if (o.dbytes !== 4'd0) begin bad++; $display("FAIL anack_bytes got=%0d exp=0", o.dbytes); end
    exp_last = 0;
  endtask

  task automatic test_data_nack();
    obs_t o;
    a_len[1] = 3;
    run_txn(2'b10, 2, 2, o);
    total++; if (o.done !== 2'b10 || o.err !== 2'b10) begin bad++;
      $display("FAIL dnack_done got=%b/%b exp=10/10", o.done, o.err); end
    total++; if (o.bytes != 2 || o.dbytes !== 4'd2) begin bad++;
      $display("FAIL dnack_bytes got=%0d/%0d exp=2/2", o.bytes, o.dbytes); end
    exp_last = 1;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int cnt;
    bit seen;
    a_addr[0] = 7'h33; a_len[0] = 0;
    load_bus();
    req = 2'b01;
    cnt = 0;
    while (gnt === 2'b00 && cnt < 20) begin @(negedge clk); cnt++; end
    @(negedge clk);
    drive_state(ST_START); drive_state(ST_ADDR); drive_state(ST_ACK_ADDR);
    m_state = ST_WR_RD;
    @(negedge clk);
    total++; if (gnt !== 2'b01 || m_stop !== 1'b1) begin bad++;
      $display("FAIL rmid_pre got=%b/%b exp=01/1", gnt, m_stop); end
    reset_n = 1'b0;
    #1;
    total++; if ({gnt, m_start, m_stop} !== 4'b0 || dbg_state !== 2'b00) begin bad++;
      $display("FAIL rmid_async got=%b/%0d exp=0/0", {gnt, m_start, m_stop}, dbg_state); end
    req = 2'b00; m_state = ST_IDLE; seen = 0;
    repeat (3) begin @(negedge clk); if (done !== 2'b00 || err !== 2'b00) seen = 1; end
    reset_n = 1'b1;
    exp_last = 1;
    repeat (2) begin @(negedge clk); if (done !== 2'b00 || err !== 2'b00) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL rmid_no_done got=pulse exp=none"); end
    a_len[1] = 0;
    run_txn(2'b11, 0, 0, o);
    total++; if (o.gnt !== 2'b01 || o.done !== 2'b01 || o.err !== 2'b00) begin bad++;
      $display("FAIL rmid_after got=%b/%b/%b exp=01/01/00", o.gnt, o.done, o.err); end
    exp_last = 0;
    run_txn(2'b10, 0, 0, o);
    exp_last = 1;
  endtask

  task automatic test_random();
    obs_t o;
    logic [1:0]  left, rv, w;
    logic [31:0] es;
    int wi, mode, nb, eb, el;
    logic ee;
    left = 2'b00;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++)
        if (!left[i]) begin
          a_addr[i] = 7'($urandom); a_rw[i] = 1'($urandom); a_len[i] = $urandom_range(15, 0);
        end
      rv = left | 2'($urandom_range(3, 1));
      w = (left != 2'b00) ? left : rr_pick(rv);
      wi = w[1] ? 1 : 0;
      el = a_len[wi] + 1;
      mode = $urandom_range(2, 0);
      nb = $urandom_range(el, 1);
      run_txn(rv, mode, nb, o);
      eb = (mode == 1) ? 0 : ((mode == 2 && nb < el) ? nb : el);
      es = (eb == el) ? (32'd1 << a_len[wi]) : 32'd0;
      ee = (mode == 1) || (mode == 2 && nb < el);
      total++; if (o.gnt !== w || o.glat != ((left != 2'b00) ? 0 : 1)) begin bad++;
        $display("FAIL rand_gnt n=%0d got=%b/%0d exp=%b", n, o.gnt, o.glat, w); end
      total++; if (o.addr !== a_addr[wi] || o.rw !== a_rw[wi]) begin bad++;
        $display("FAIL rand_addr n=%0d got=%h/%b exp=%h/%b", n, o.addr, o.rw, a_addr[wi], a_rw[wi]); end
      total++; if (o.bytes != eb || o.stop !== es) begin bad++;
        $display("FAIL rand_bytes n=%0d got=%0d/%h exp=%0d/%h", n, o.bytes, o.stop, eb, es); end
      total++; if (o.done !== w || o.err !== (ee ? w : 2'b00) || o.dlat != 1) begin bad++;
        $display("FAIL rand_done n=%0d got=%b/%b/%0d exp=%b/%b", n, o.done, o.err, o.dlat, w, ee ? w : 2'b00); end
      total++; if (o.post_gnt !== (rv & ~w) || o.start !== 2'b10 || o.done_after) begin bad++;
        $display("FAIL rand_after n=%0d got=%b/%b exp=%b/10", n, o.post_gnt, o.start, rv & ~w); end
      exp_last = wi;
      left = rv & ~w;
    end
    if (left != 2'b00) begin
      run_txn(left, 0, 0, o);
      total++; if (o.gnt !== left) begin bad++; $display("FAIL rand_drain got=%b exp=%b", o.gnt, left); end
      exp_last = left[1] ? 1 : 0;
    end
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    a_len[0] = 2;
    load_bus();
    req = 2'b01;
    cnt = 0;
    while (gnt === 2'b00 && cnt < 20) begin @(negedge clk); cnt++; end
    @(negedge clk);
    drive_state(ST_START); drive_state(ST_ADDR); drive_state(ST_ACK_ADDR);
    m_state = ST_WR_RD;
    cnt = 0;
    while (done === 2'b00 && cnt < 40) begin @(negedge clk); cnt++; end
    total++; if (cnt != 16 || done !== 2'b01 || err !== 2'b01 || gnt !== 2'b00) begin bad++;
      $display("FAIL timeout got=%0d/%b/%b/%b exp=16/01/01/00", cnt, done, err, gnt); end
    req = 2'b00;
    @(negedge clk);
    total++; if (dbg_state !== 2'b00 || done !== 2'b00) begin bad++;
      $display("FAIL timeout_idle got=%0d/%b exp=0/00", dbg_state, done); end
    m_state = ST_IDLE;
    @(negedge clk);
    exp_last = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_write_1byte();
    test_read_3byte();
    test_contention();
    test_addr_nack();
    test_data_nack();
    test_reset_mid();
    test_random();
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Transaction-level controller in front of the basic I2C master's SCL state machine. Two requesters share the single master. A round-robin arbiter grants the bus to one requester at a time. The block then sequences a complete transaction: it drives the master's start/stop controls, counts data bytes from the master's state sequence, detects NACKs, and reports completion and error per requester.

## Interface
- ADDR_BIT, 7: slave address width forwarded to the master.
- LEN_BIT, 4: byte-count field width; field value = bytes − 1, so 1..2^LEN_BIT bytes per transaction.
- TIMEOUT_CYCLES, 4096: clk cycles without any master state change before abort (only with the timeout feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester level request; held until its done pulse.
- req_addr  in  2*ADDR_BIT  slave address; requester i at bits [i*ADDR_BIT +: ADDR_BIT].
- req_rw  in  2  per-requester read(1)/write(0).
- req_len  in  2*LEN_BIT  per-requester byte count − 1.
- gnt  out  2  one-hot grant, held for the whole transaction.
- done  out  2  one-cycle completion pulse to the granted requester.
- err  out  2  one-cycle error pulse, coincident with done.
- m_start  out  1  start request to the master.
- m_stop  out  1  stop request to the master, sampled by it in ACK_WR_RD.
- m_addr  out  ADDR_BIT  latched address; stable from grant to done.
- m_rw  out  1  latched direction; stable from grant to done.
- m_state  in  3  master state, already synchronized to clk: IDLE 000, START 001, ADDR 010, ACK_ADDR 011, WR_RD 100, ACK_WR_RD 101, STOP 110.
- m_sda  in  1  SDA line, synchronized.

## Operation
- Controller states: IDLE, LAUNCH, XFER, FINISH.
- IDLE:
  - If any req bit is set, grant one requester (arbitration below).
  - On grant: latch that requester's addr, rw and len; clear the byte counter; go to LAUNCH.
- Round-robin arbitration:
  - A last-grant pointer resets to 1, so requester 0 wins the first contest.
  - With both req bits set, the requester not granted last wins.
  - With a single req bit set, that requester wins.
- LAUNCH:
  - Hold m_start=1 until m_state ≠ IDLE, then deassert m_start and go to XFER.
- XFER (track a registered copy of m_state, prev_state):
  - Byte completion: prev_state = ACK_WR_RD and m_state ≠ ACK_WR_RD. Increment bytes_done on each completion.
  - m_stop = (bytes_done == latched len). It therefore rises after the second-to-last byte completes, ahead of the last ACK_WR_RD.
  - Address NACK: prev_state = ACK_ADDR and m_state = STOP. Set the internal err flag.
  - Data NACK: prev_state = ACK_WR_RD, m_state = STOP and m_stop = 0. Set the err flag.
  - When m_state = STOP, go to FINISH.
- FINISH:
  - Wait for m_state = IDLE.
  - Then pulse done[g] and err[g] (if the err flag is set); clear gnt, m_stop and the err flag.
  - Update the pointer to g and return to IDLE.
- Requester drops req mid-transaction: ignored. The transaction completes and done still pulses.
- req_* inputs change after grant: ignored, because the values are already latched.

## Timing
- Reset values: gnt=0, done=0, err=0, m_start=0, m_stop=0, m_addr=0, m_rw=0, pointer=1, controller state IDLE, bytes_done=0.
- Reset asserted mid-transaction: all of the above take effect immediately. No done or err pulse is issued.
- Grant latency: req sampled high in IDLE → gnt registered high and m_start high on the next posedge.
- done/err: asserted exactly one cycle, on the cycle after m_state is first seen as IDLE in FINISH. gnt falls in that same cycle.
- Back-to-back: the earliest next grant is the cycle after done. There is no overlap between transactions.
- The byte counter saturates at its max value; it never wraps.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - A watchdog counter clears on every m_state change and while the controller is in IDLE.
  - When it reaches TIMEOUT_CYCLES in LAUNCH, XFER or FINISH: pulse done[g] and err[g], drop m_start and m_stop, clear gnt, update the pointer and return to IDLE.
- Not defined: no watchdog; the controller waits indefinitely, and TIMEOUT_CYCLES is unused.

## Test plan
- Write, 1 byte: req=01, addr 0x50, len=0, master model ACKs everything → m_stop high from the XFER entry; gnt=01; done=01 with err=00 after STOP→IDLE.
- Read, 3 bytes: req=10, len=2 → m_stop rises after the 2nd completion; exactly 3 ACK_WR_RD exits; done=10, err=00.
- Contention: req=11 held for two transactions → grants are 01 then 10; swap the order and confirm alternation on the next pair.
- Address NACK: master model goes ACK_ADDR→STOP → done=01, err=01; bytes_done=0.
- Reset mid-XFER: deassert reset_n during WR_RD → gnt, m_start, m_stop = 0 at once, no done; a fresh req=01 after release is granted normally.
- I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: freeze m_state at WR_RD → done and err pulse 16 cycles after the last state change, then IDLE.
